// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - Start/Halt request and run-status bundle between top-level and run sequencer
interface run_sequencer_if #(
    parameter int CYC_W = 16
);
    logic             Start;
    logic             Halt;
    logic             PcInit;
    logic             RunEn;
    logic             Ack;
    logic             Timeout;
    logic [CYC_W-1:0] CycCnt;

    modport master (
        output Start, Halt,
        input  PcInit, RunEn, Ack, Timeout, CycCnt
    );

    modport slave (
        input  Start, Halt,
        output PcInit, RunEn, Ack, Timeout, CycCnt
    );
endinterface

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - program-run controller: Start -> PC init -> run until halt/watchdog -> drain -> Ack
module run_sequencer #(
    parameter int          CYC_W     = 16,
    parameter int unsigned MAX_CYC   = 16'hFFFF,
    parameter int          DRAIN_CYC = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    run_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [CYC_W-1:0] WD_LAST    = CYC_W'(MAX_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic             start_q;
    logic             start_rise;
    logic [CYC_W-1:0] cyc_cnt;
    logic             timeout;
    logic [DW-1:0]    drain_cnt;
    logic             run_stop;

    assign start_rise = bus.Start & ~start_q;
    // Halt and watchdog both end the run; only the watchdog (without Halt) flags Timeout.
    assign run_stop   = bus.Halt | (cyc_cnt == WD_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            cyc_cnt   <= '0;
            timeout   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state   <= next_state;
            start_q <= bus.Start;
            if (next_state == S_INIT) begin
                cyc_cnt <= '0;
                timeout <= 1'b0;
            end else if (state == S_RUN) begin
                cyc_cnt <= cyc_cnt + 1'b1;
                if (!bus.Halt && cyc_cnt == WD_LAST) begin
                    timeout <= 1'b1;
                end
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_rise) next_state = S_INIT;
            S_INIT:  next_state = S_RUN;
            S_RUN:   if (run_stop) next_state = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = S_DONE;
            S_DONE:  if (start_rise) next_state = S_INIT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PcInit  = (state == S_INIT);
        bus.RunEn   = (state == S_RUN);
        bus.Ack     = (state == S_DONE);
        bus.Timeout = timeout;
        bus.CycCnt  = cyc_cnt;
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed plus random bench for run_sequencer against a run-timeline model
module tb_run_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic halt;

    always #5 clk = ~clk;

    run_sequencer_if #(.CYC_W(16)) bus_a ();
    run_sequencer_if #(.CYC_W(16)) bus_b ();

    assign bus_a.Start = start;
    assign bus_a.Halt  = halt;
    assign bus_b.Start = start;
    assign bus_b.Halt  = halt;

    run_sequencer #(.CYC_W(16), .MAX_CYC(8), .DRAIN_CYC(2)) dut_a (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus_a)
    );

    run_sequencer #(.CYC_W(16), .MAX_CYC(5), .DRAIN_CYC(0)) dut_b (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;
    // Model per instance: launch edge, stop edge (-1 = none yet), timeout flag, previous Start.
    int launch_e [2] = '{-1, -1};
    int stop_e   [2] = '{-1, -1};
    bit to_flag  [2] = '{1'b0, 1'b0};
    bit start_p  [2] = '{1'b0, 1'b0};
    int max_cyc  [2] = '{8, 5};
    int drain    [2] = '{2, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                launch_e[i] = -1;
                stop_e[i]   = -1;
                to_flag[i]  = 1'b0;
                start_p[i]  = 1'b0;
            end else begin
                bit rise;
                bit running;
                bit free;
                rise       = start && !start_p[i];
                start_p[i] = start;
                running = (launch_e[i] >= 0) && (stop_e[i] < 0) && (e - 1 >= launch_e[i] + 1);
                free    = (launch_e[i] < 0) || ((stop_e[i] >= 0) && (e - 1 >= stop_e[i] + drain[i]));
                if (running) begin
                    if (halt) begin
                        stop_e[i] = e;
                    end else if (e == launch_e[i] + 1 + max_cyc[i]) begin
                        stop_e[i]  = e;
                        to_flag[i] = 1'b1;
                    end
                end else if (free && rise) begin
                    launch_e[i] = e;
                    stop_e[i]   = -1;
                    to_flag[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int  l;
            int  s;
            bit  x_pc;
            bit  x_run;
            bit  x_ack;
            int  x_cyc;
            l     = launch_e[i];
            s     = stop_e[i];
            x_pc  = (l >= 0) && (e == l);
            x_run = (l >= 0) && (e > l) && ((s < 0) || (e < s));
            x_ack = (l >= 0) && (s >= 0) && (e >= s + drain[i]);
            if (l < 0)       x_cyc = 0;
            else if (s >= 0) x_cyc = s - l - 1;
            else             x_cyc = (e - l - 1 > 0) ? e - l - 1 : 0;
            if (i == 0) begin
                chk("a.PcInit",  32'(bus_a.PcInit),  32'(x_pc));
                chk("a.RunEn",   32'(bus_a.RunEn),   32'(x_run));
                chk("a.Ack",     32'(bus_a.Ack),     32'(x_ack));
                chk("a.Timeout", 32'(bus_a.Timeout), 32'(to_flag[0]));
                chk("a.CycCnt",  32'(bus_a.CycCnt),  32'(x_cyc));
            end else begin
                chk("b.PcInit",  32'(bus_b.PcInit),  32'(x_pc));
                chk("b.RunEn",   32'(bus_b.RunEn),   32'(x_run));
                chk("b.Ack",     32'(bus_b.Ack),     32'(x_ack));
                chk("b.Timeout", 32'(bus_b.Timeout), 32'(to_flag[1]));
                chk("b.CycCnt",  32'(bus_b.CycCnt),  32'(x_cyc));
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit h);
        reset = r;
        start = s;
        halt  = h;
        @(posedge clk);
        e++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n, input bit s, input bit h);
        for (int k = 0; k < n; k++) step(1'b0, s, h);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        halt  = 1'b0;

        // Reset, then a run halted on its 5th RUN cycle
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        steps(5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(4, 1'b0, 1'b0);

        // Watchdog: Halt never asserted
        step(1'b0, 1'b1, 1'b0);
        steps(15, 1'b0, 1'b0);

        // Halt on the 8th RUN cycle of dut_a
        step(1'b0, 1'b1, 1'b0);
        steps(8, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(4, 1'b0, 1'b0);

        // Start pulses during RUN/DRAIN, Start held through DONE, then a fresh edge
        step(1'b0, 1'b1, 1'b0);
        steps(3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        steps(6, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        steps(3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Reset mid-RUN at CycCnt=3, then a normal run
        step(1'b0, 1'b1, 1'b0);
        steps(4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(4, 1'b0, 1'b1);

        // Start already high on the first post-reset edge counts as a rising edge
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        steps(3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
